// File: rtl/en_missiles.sv
// en_missiles: enemy missile engine in the VGA pixel pipeline.
//
// Up to three falling missiles, one per slot. Each slot cools down, then
// launches from its enemy's launch point, falls a level-dependent number of
// pixels per frame, and retires when it leaves the screen or hits the player.
// The pixel stream passes through with 1 cycle of latency. Missile pixels are
// painted in MIS_RGB outside blanking.
//
// Optional feature: define EN_MISSILE_COLLISION_EN to build the player overlap
// check and player_hit. When it is undefined, player_hit is constant 0 and
// missiles leave only by going off-screen.
//
// Ports:
//   pclk, rst            pixel clock, async active-low reset
//   vcount_in/hcount_in  timing counters (11b)
//   vsync/hsync/vblnk/hblnk_in, rgb_in   timing strobes, pixel colour
//   en1..en3_x/y_missile launch points (x == 0: enemy dead, no launch)
//   xpos/ypos_player     player hitbox top-left
//   level_in, level_change  level and its one-cycle transition pulse
//   *_out                pixel stream delayed 1 cycle
//   player_hit           1-cycle pulse per frame with at least one hit

// One missile slot: IDLE -> COOL -> FLY state machine and pixel coverage test.
module en_missiles_slot #(
  parameter int         SCREEN_H = 600,
  parameter int         MIS_W    = 4,
  parameter int         MIS_H    = 12,
  parameter int         PL_W     = 48,
  parameter int         PL_H     = 40,
  parameter logic [5:0] PRELOAD  = 6'd20
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        level_change,
  input  logic [3:0]  step,
  input  logic [5:0]  reload,
  input  logic [10:0] launch_x,
  input  logic [10:0] launch_y,
  input  logic [10:0] xpos_player,
  input  logic [10:0] ypos_player,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        pix,
  output logic        hit
);
  typedef enum logic [1:0] {S_IDLE, S_COOL, S_FLY} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [10:0] x, y, x_n, y_n;
  logic [11:0] xw, yw, ny;
  logic        off, overlap;

  // 12-bit arithmetic so x+MIS_W / y+step never wrap
  assign xw  = {1'b0, x};
  assign yw  = {1'b0, y};
  assign ny  = yw + {8'd0, step};
  assign off = ny >= 12'(SCREEN_H);

`ifdef EN_MISSILE_COLLISION_EN
  // strict overlap of the moved missile rectangle with the player rectangle
  assign overlap = (xw < {1'b0, xpos_player} + 12'(PL_W)) &&
                   ({1'b0, xpos_player} < xw + 12'(MIS_W)) &&
                   (ny < {1'b0, ypos_player} + 12'(PL_H)) &&
                   ({1'b0, ypos_player} < ny + 12'(MIS_H));
`else
  logic unused_player;
  assign unused_player = ^{xpos_player, ypos_player};
  assign overlap       = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state <= S_COOL;
      cnt   <= PRELOAD;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    y_n     = y;
    hit     = 1'b0;
    if (level_change) begin
      // level change beats tick: missile vanishes, no hit
      state_n = S_COOL;
      cnt_n   = PRELOAD;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          state_n = S_COOL;
          cnt_n   = reload;
        end
        S_COOL: begin
          if (cnt > 6'd1) begin
            cnt_n = cnt - 6'd1;
          end else begin
            // expired: park at 0 and retry every tick while the enemy is dead
            cnt_n = '0;
            if (launch_x != '0) begin
              state_n = S_FLY;
              x_n     = launch_x;
              y_n     = launch_y;
            end
          end
        end
        S_FLY: begin
          if (off) begin
            state_n = S_IDLE;
          end else if (overlap) begin
            state_n = S_IDLE;
            hit     = 1'b1;
          end else begin
            y_n = ny[10:0];
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign pix = (state == S_FLY) &&
               (hcount >= x) && ({1'b0, hcount} < xw + 12'(MIS_W)) &&
               (vcount >= y) && ({1'b0, vcount} < yw + 12'(MIS_H));
endmodule

module en_missiles #(
  parameter int          SCREEN_H = 600,
  parameter int          MIS_W    = 4,
  parameter int          MIS_H    = 12,
  parameter int          PL_W     = 48,
  parameter int          PL_H     = 40,
  parameter logic [11:0] MIS_RGB  = 12'hF80
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] en1_x_missile,
  input  logic [10:0] en1_y_missile,
  input  logic [10:0] en2_x_missile,
  input  logic [10:0] en2_y_missile,
  input  logic [10:0] en3_x_missile,
  input  logic [10:0] en3_y_missile,
  input  logic [10:0] xpos_player,
  input  logic [10:0] ypos_player,
  input  logic [3:0]  level_in,
  input  logic        level_change,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        player_hit
);
  localparam int NUM_SLOTS = 3;

  logic [NUM_SLOTS-1:0][10:0] lx, ly;
  logic [NUM_SLOTS-1:0]       pix, hit;
  logic                       vblnk_q, tick;
  logic [3:0]                 lvl_st, lvl_cd, step;
  logic [5:0]                 reload;

  assign lx = {en3_x_missile, en2_x_missile, en1_x_missile};
  assign ly = {en3_y_missile, en2_y_missile, en1_y_missile};

  // vblnk_q resets high so a vblnk already asserted at reset release is not
  // taken as a frame tick; the first tick needs a fresh rising edge.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) vblnk_q <= 1'b1;
    else      vblnk_q <= vblnk_in;
  end
  assign tick = vblnk_in & ~vblnk_q;

  // step 2..8 px/frame, cooldown 60..20 frames
  assign lvl_st = (level_in > 4'd6)  ? 4'd6  : level_in;
  assign lvl_cd = (level_in > 4'd10) ? 4'd10 : level_in;
  assign step   = 4'd2 + lvl_st;
  assign reload = 6'd60 - {lvl_cd, 2'b00};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    en_missiles_slot #(
      .SCREEN_H(SCREEN_H), .MIS_W(MIS_W), .MIS_H(MIS_H),
      .PL_W(PL_W), .PL_H(PL_H), .PRELOAD(6'(20 * (i + 1)))
    ) u_slot (
      .pclk(pclk), .rst(rst), .tick(tick), .level_change(level_change),
      .step(step), .reload(reload),
      .launch_x(lx[i]), .launch_y(ly[i]),
      .xpos_player(xpos_player), .ypos_player(ypos_player),
      .hcount(hcount_in), .vcount(vcount_in),
      .pix(pix[i]), .hit(hit[i])
    );
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vcount_out <= '0;
      hcount_out <= '0;
      vsync_out  <= 1'b0;
      hsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
      player_hit <= 1'b0;
    end else begin
      vcount_out <= vcount_in;
      hcount_out <= hcount_in;
      vsync_out  <= vsync_in;
      hsync_out  <= hsync_in;
      vblnk_out  <= vblnk_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= (|pix && !hblnk_in && !vblnk_in) ? MIS_RGB : rgb_in;
      // hit is only ever set on a tick without level_change; slots OR'd
      player_hit <= |hit;
    end
  end
endmodule

// File: tb/tb_en_missiles.sv
// Scoreboard bench for en_missiles: the driver pushes the expected pixel
// output computed from a frame-level model of the missile slots, the monitor
// pops and compares one entry per clock.
module tb_en_missiles;
  localparam int SH = 600, MW = 4, MH = 12, PW = 48, PH = 40;

  logic        pclk = 1'b0, rst = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 0, hsync_in = 0, vblnk_in = 1, hblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic [10:0] en1_x_missile, en1_y_missile, en2_x_missile, en2_y_missile;
  logic [10:0] en3_x_missile, en3_y_missile, xpos_player, ypos_player;
  logic [3:0]  level_in = '0;
  logic        level_change = 0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out, player_hit;
  logic [11:0] rgb_out;

  en_missiles dut (
    .pclk(pclk), .rst(rst), .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in),
    .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .en1_x_missile(en1_x_missile), .en1_y_missile(en1_y_missile),
    .en2_x_missile(en2_x_missile), .en2_y_missile(en2_y_missile),
    .en3_x_missile(en3_x_missile), .en3_y_missile(en3_y_missile),
    .xpos_player(xpos_player), .ypos_player(ypos_player),
    .level_in(level_in), .level_change(level_change),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out),
    .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .player_hit(player_hit)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [10:0] v, h;
    logic        vs, hs, vb, hb;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  bit   mon_en = 0;

  // model: mode 0 idle, 1 cooling, 2 falling
  int mode[3], cnt[3], mx[3], my[3];
  int lxa[3], lya[3];
  int px = 700, py = 560, lvl = 0;
  bit prev_vb = 1;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit covered(int h, int v);
    for (int s = 0; s < 3; s++)
      if (mode[s] == 2 && h >= mx[s] && h < mx[s] + MW && v >= my[s] && v < my[s] + MH)
        return 1;
    return 0;
  endfunction

  function automatic bit collide(int s, int ny);
`ifdef EN_MISSILE_COLLISION_EN
    return (mx[s] < px + PW) && (px < mx[s] + MW) && (ny < py + PH) && (py < ny + MH);
`else
    return 0;
`endif
  endfunction

  task automatic preload_all();
    for (int s = 0; s < 3; s++) begin
      mode[s] = 1;
      cnt[s]  = 20 * (s + 1);
    end
  endtask

  // one frame of slot behaviour; returns whether any missile struck
  function automatic bit frame_step();
    bit any = 0;
    int stp = 2 + imin(lvl, 6);
    int rl  = 60 - 4 * imin(lvl, 10);
    for (int s = 0; s < 3; s++) begin
      if (mode[s] == 0) begin
        mode[s] = 1; cnt[s] = rl;
      end else if (mode[s] == 1) begin
        cnt[s] = (cnt[s] > 1) ? cnt[s] - 1 : 0;
        if (cnt[s] == 0 && lxa[s] != 0) begin
          mode[s] = 2; mx[s] = lxa[s]; my[s] = lya[s];
        end
      end else begin
        if (my[s] + stp >= SH) mode[s] = 0;
        else if (collide(s, my[s] + stp)) begin
          mode[s] = 0; any = 1;
        end else my[s] = my[s] + stp;
      end
    end
    return any;
  endfunction

  task automatic cyc(input int h, input int v, input bit hb, input bit vb,
                     input bit lc, input logic [11:0] rgb);
    exp_t e;
    bit   tk;
    @(negedge pclk);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; level_change = lc; rgb_in = rgb;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    level_in = 4'(lvl);
    en1_x_missile = 11'(lxa[0]); en1_y_missile = 11'(lya[0]);
    en2_x_missile = 11'(lxa[1]); en2_y_missile = 11'(lya[1]);
    en3_x_missile = 11'(lxa[2]); en3_y_missile = 11'(lya[2]);
    xpos_player = 11'(px); ypos_player = 11'(py);
    e.v = 11'(v); e.h = 11'(h); e.vs = vsync_in; e.hs = hsync_in;
    e.vb = vb; e.hb = hb;
    e.rgb = (covered(h, v) && !hb && !vb) ? 12'hF80 : rgb;
    e.hit = 0;
    tk = vb && !prev_vb;
    prev_vb = vb;
    if (lc) preload_all();
    else if (tk) e.hit = frame_step();
    q.push_back(e);
  endtask

  function automatic int clamp0(int a);
    return (a < 0) ? 0 : a;
  endfunction

  // random pixels (half of them near a falling missile), optional full scan
  // around each falling missile, then the vblank rise carrying the tick
  task automatic frame(input bit lc_tick, input bit scan, input int npix);
    int h, v, s;
    for (int n = 0; n < npix; n++) begin
      s = int'($urandom_range(0, 2));
      if (mode[s] == 2 && $urandom_range(0, 1) == 1) begin
        h = clamp0(mx[s] + int'($urandom_range(0, MW + 3)) - 2);
        v = clamp0(my[s] + int'($urandom_range(0, MH + 3)) - 2);
      end else begin
        h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 599));
      end
      cyc(h, v, ($urandom_range(0, 7) == 0), 0, 0, 12'($urandom));
    end
    if (scan)
      for (int k = 0; k < 3; k++)
        if (mode[k] == 2)
          for (int vv = my[k] - 2; vv < my[k] + MH + 2; vv++)
            for (int hh = mx[k] - 2; hh < mx[k] + MW + 2; hh++)
              if (vv >= 0 && hh >= 0) cyc(hh, vv, 0, 0, 0, 12'($urandom));
    cyc(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), 0, 1, lc_tick, 12'($urandom));
    // blanked pixel inside a missile if one exists: must pass through
    s = int'($urandom_range(0, 2));
    if (mode[s] == 2) cyc(mx[s], my[s], 0, 1, 0, 12'($urandom));
    else              cyc(10, 10, 1, 1, 0, 12'($urandom));
  endtask

  // monitor
  initial begin
    exp_t e, got;
    forever begin
      @(posedge pclk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        got = {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out,
               hblnk_out, rgb_out, player_hit};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pixel h=%0d v=%0d: got rgb=%h hit=%b vc=%0d hc=%0d sync=%b%b blnk=%b%b, want rgb=%h hit=%b vc=%0d hc=%0d sync=%b%b blnk=%b%b",
                   e.h, e.v, got.rgb, got.hit, got.v, got.h, got.vs, got.hs, got.vb, got.hb,
                   e.rgb, e.hit, e.v, e.h, e.vs, e.hs, e.vb, e.hb);
        end
      end
    end
  end

  initial begin
    lxa = '{100, 0, 0}; lya = '{50, 0, 0};
    en1_x_missile = 11'd100; en1_y_missile = 11'd50;
    en2_x_missile = '0; en2_y_missile = '0; en3_x_missile = '0; en3_y_missile = '0;
    xpos_player = 11'd700; ypos_player = 11'd560;
    preload_all();
    // reset with busy inputs: outputs must stay 0
    hcount_in = 11'd123; vcount_in = 11'd45; rgb_in = 12'hABC;
    hsync_in = 1; vsync_in = 1; hblnk_in = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      checks++;
      if ({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out, player_hit} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got rgb=%h vc=%0d hc=%0d hit=%b, want all 0",
                 rgb_out, vcount_out, hcount_out, player_hit);
      end
    end
    @(negedge pclk);
    rst = 1;
    mon_en = 1;
    // vblnk still high after release: no tick
    cyc(5, 5, 0, 1, 0, 12'h123);
    cyc(6, 5, 0, 1, 0, 12'h456);

    // level 0: slot1 launches on tick 20, exits on its 275th fall;
    // slot2 dead until x becomes 150 before tick 45; slot3 stays dead
    for (int f = 1; f <= 300; f++) begin
      if (f == 45) begin lxa[1] = 150; lya[1] = 80; end
      frame(0, (f == 20 || f == 21 || f == 46 || f % 50 == 0 || f == 296), 3);
    end

    // directed drawing and level_change priority
    lxa = '{200, 260, 320}; lya = '{300, 100, 120};
    cyc(1, 1, 0, 0, 1, 12'h111);           // level_change off the tick
    for (int f = 1; f <= 60; f++) frame(0, (f == 21 || f == 60), 2);
    px = 190; py = 380;                    // overlaps slot1's next position
    frame(1, 0, 0);                        // level_change on the tick
    cyc(200, 382, 0, 0, 0, 12'h222);       // vanished missiles
    cyc(260, 222, 0, 0, 0, 12'h333);
    for (int f = 1; f <= 25; f++) frame(0, (f == 22), 2);

    // level 6 hit on the first fall
    px = 700; py = 560; lvl = 6;
    cyc(1, 1, 0, 0, 1, 12'h444);
    px = 190; py = 316;
    for (int f = 1; f <= 24; f++) frame(0, (f >= 20), 2);
    px = 700; py = 560;

    // randomized
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        int s = int'($urandom_range(0, 2));
        lxa[s] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 790));
        lya[s] = int'($urandom_range(0, 400));
      end
      if ($urandom_range(0, 3) == 0) begin
        int s = int'($urandom_range(0, 2));
        if (mode[s] == 2) begin
          px = clamp0(mx[s] - int'($urandom_range(0, 50)));
          py = clamp0(my[s] + int'($urandom_range(0, 30)) - 10);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        px = int'($urandom_range(0, 750)); py = int'($urandom_range(0, 560));
      end
      if ($urandom_range(0, 39) == 0) begin
        lvl = int'($urandom_range(0, 15));
        frame($urandom_range(0, 1) == 1, 0, 2);
      end else if ($urandom_range(0, 59) == 0) begin
        lvl = int'($urandom_range(0, 15));
        cyc(3, 3, 0, 0, 1, 12'($urandom));
        frame(0, 0, 2);
      end else begin
        frame(0, ($urandom_range(0, 9) == 0), 3);
      end
    end

    @(posedge pclk); #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
